// File: rtl/inst_dispatch_buffer.sv
// Dispatch buffer between the instruction queue and the issue stage: a circular FIFO
// with first-word-fall-through read, fetch stall when full, and a single-cycle flush.
module inst_dispatch_buffer #(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int DROP_NOP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       in_opcode,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_immediate,
    input  logic [25:0]       in_address,
    input  logic [31:0]       in_pc,
    input  logic              in_valid,
    output logic              fetch_stall,
    output logic [11:0]       out_opcode,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_shamt,
    output logic [15:0]       out_immediate,
    output logic [25:0]       out_address,
    output logic [31:0]       out_pc,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);
    localparam int              ENTRY_W    = 106;
    localparam int              FIELD_W    = ENTRY_W - 32;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    // The PC is not part of the instruction word, so it is ignored when spotting a nop.
    function automatic logic is_nop(input logic [FIELD_W-1:0] fields);
        return (DROP_NOP != 0) && (fields == {FIELD_W{1'b0}});
    endfunction

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0]  head_r;
    logic [ADDR_W-1:0]  tail_r;
    logic [ADDR_W:0]    count_r;
    logic               overflow_r;

    logic [ENTRY_W-1:0] in_entry_s;
    logic [ENTRY_W-1:0] head_entry_s;
    logic               nop_s;
    logic               full_s;
    logic               deq_s;
    logic               enq_s;
    logic               drop_s;

    assign in_entry_s   = {in_opcode, in_rs, in_rt, in_rd, in_shamt,
                           in_immediate, in_address, in_pc};
    assign head_entry_s = mem_r[head_r];
    assign {out_opcode, out_rs, out_rt, out_rd, out_shamt,
            out_immediate, out_address, out_pc} = head_entry_s;
    assign out_valid    = (count_r != {(ADDR_W + 1){1'b0}});
    assign fetch_stall  = full_s;
    assign count        = count_r;
    assign overflow     = overflow_r;

    // Handshake decode: a write into a full buffer only succeeds alongside a dequeue.
    always_comb begin
        nop_s  = is_nop(in_entry_s[ENTRY_W-1:32]);
        full_s = (count_r == FULL_COUNT);
        deq_s  = out_valid & out_ready;
        enq_s  = in_valid & ~nop_s & (~full_s | deq_s);
        drop_s = in_valid & ~nop_s & full_s & ~deq_s;
    end

    // Pointer, occupancy and sticky overflow state; reset outranks flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r     <= {ADDR_W{1'b0}};
            tail_r     <= {ADDR_W{1'b0}};
            count_r    <= {(ADDR_W + 1){1'b0}};
            overflow_r <= 1'b0;
        end else if (flush) begin
            head_r     <= {ADDR_W{1'b0}};
            tail_r     <= {ADDR_W{1'b0}};
            count_r    <= {(ADDR_W + 1){1'b0}};
            overflow_r <= overflow_r;
        end else begin
            if (enq_s) begin
                tail_r <= tail_r + ADDR_W'(1);
            end
            if (deq_s) begin
                head_r <= head_r + ADDR_W'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + (ADDR_W + 1)'(1);
                2'b01:   count_r <= count_r - (ADDR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Entry storage; contents carry no reset since out_* is ignored while empty.
    always_ff @(posedge clk) begin
        if (enq_s && !flush && !rst) begin
            mem_r[tail_r] <= in_entry_s;
        end
    end
endmodule

// File: tb/tb_inst_dispatch_buffer.sv
// Self-checking bench for inst_dispatch_buffer: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_inst_dispatch_buffer;
    localparam int DEPTH    = 8;
    localparam int ADDR_W   = 3;
    localparam int DROP_NOP = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, out_ready, flush;
    logic [105:0] in_word;
    logic [11:0]  in_opcode;
    logic [4:0]   in_rs, in_rt, in_rd, in_shamt;
    logic [15:0]  in_immediate;
    logic [25:0]  in_address;
    logic [31:0]  in_pc;
    logic         fetch_stall, out_valid, overflow;
    logic [11:0]  out_opcode;
    logic [4:0]   out_rs, out_rt, out_rd, out_shamt;
    logic [15:0]  out_immediate;
    logic [25:0]  out_address;
    logic [31:0]  out_pc;
    logic [ADDR_W:0] count;
    logic [105:0] out_word;

    assign {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_immediate, in_address, in_pc} = in_word;
    assign out_word = {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_immediate, out_address, out_pc};

    inst_dispatch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DROP_NOP(DROP_NOP)) dut (
        .clk(clk), .rst(rst),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_immediate(in_immediate), .in_address(in_address),
        .in_pc(in_pc), .in_valid(in_valid), .fetch_stall(fetch_stall),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_immediate(out_immediate), .out_address(out_address),
        .out_pc(out_pc), .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
        .count(count), .overflow(overflow)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered list of accepted instructions plus the sticky flag.
    logic [105:0] mq[$];
    logic         m_ovf;

    typedef struct {
        logic        r, v, rdy, f;
        logic [31:0] pc;
        int          e_count;
        logic        e_valid, e_stall, e_ovf;
        logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [105:0] add_word(input logic [31:0] pc);
        return {12'h020, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, pc};
    endfunction

    function automatic vec_t mk(input logic r, v, rdy, f, input logic [31:0] pc,
                                input int ec, input logic ev, es, eo, input logic [31:0] ep);
        vec_t t;
        t.r = r; t.v = v; t.rdy = rdy; t.f = f; t.pc = pc;
        t.e_count = ec; t.e_valid = ev; t.e_stall = es; t.e_ovf = eo; t.e_pc = ep;
        return t;
    endfunction

    task automatic chk(input string name, input logic [105:0] act, input logic [105:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("count", 106'(count), 106'(mq.size()));
        chk("out_valid", 106'(out_valid), 106'(mq.size() != 0));
        chk("fetch_stall", 106'(fetch_stall), 106'(mq.size() == DEPTH));
        chk("overflow", 106'(overflow), 106'(m_ovf));
        if (mq.size() != 0) chk("head_entry", out_word, mq[0]);
    endtask

    // Called at a negedge: apply inputs, let one posedge pass, then compare at the negedge.
    task automatic drive(input logic r, v, rdy, f, input logic [105:0] w);
        logic deq, nop;
        rst = r; in_valid = v; out_ready = rdy; flush = f; in_word = w;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
        end else if (f) begin
            mq.delete();
        end else begin
            deq = (mq.size() != 0) && rdy;
            nop = (DROP_NOP != 0) && (w[105:32] == 74'd0);
            if (v && !nop) begin
                if (mq.size() < DEPTH || deq) mq.push_back(w);
                else m_ovf = 1'b1;
            end
            if (deq) void'(mq.pop_front());
        end
        @(negedge clk);
        model_check();
    endtask

    initial begin
        logic [127:0] rnd;
        logic [105:0] w;
        int pct;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_word = '0;
        m_ovf = 1'b0;
        @(negedge clk);

        // Directed table: reset, fill, overflow, partial drain, then reset mid-stream.
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 0, 1'b0, 1'b0, 1'b0, 32'd0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'(i), i + 1, 1'b1, i == 7, 1'b0, 32'd0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'd8, 8, 1'b1, 1'b1, 1'b1, 32'd0));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 8 - i, 1'b1, 1'b0, 1'b1, 32'(i)));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'd9, 0, 1'b0, 1'b0, 1'b0, 32'd0));
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].rdy, tbl[i].f, add_word(tbl[i].pc));
            chk("tbl_count", 106'(count), 106'(tbl[i].e_count));
            chk("tbl_valid", 106'(out_valid), 106'(tbl[i].e_valid));
            chk("tbl_stall", 106'(fetch_stall), 106'(tbl[i].e_stall));
            chk("tbl_overflow", 106'(overflow), 106'(tbl[i].e_ovf));
            if (tbl[i].e_valid) chk("tbl_pc", 106'(out_pc), 106'(tbl[i].e_pc));
        end

        // Full buffer with concurrent enqueue/dequeue, then wrap-around streaming and drain.
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, add_word(32'(i)));
        drive(1'b0, 1'b1, 1'b1, 1'b0, add_word(32'd8));
        chk("full_swap_count", 106'(count), 106'(8));
        chk("full_swap_ovf", 106'(overflow), 106'(0));
        chk("full_swap_pc", 106'(out_pc), 106'(1));
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, add_word(32'(8 + k)));
            chk("stream_pc", 106'(out_pc), 106'(1 + k));
        end
        for (int j = 0; j < 8; j++) begin
            chk("drain_pc", 106'(out_pc), 106'(21 + j));
            drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
        end
        chk("drain_empty", 106'(out_valid), 106'(0));

        // All-zero instruction word is dropped even with a nonzero PC.
        drive(1'b0, 1'b1, 1'b0, 1'b0, {12'h200, 5'd1, 5'd2, 5'd0, 5'd0, 16'd5, 26'd0, 32'h10});
        drive(1'b0, 1'b1, 1'b0, 1'b0, {74'd0, 32'h14});
        drive(1'b0, 1'b1, 1'b0, 1'b0, {12'h8C0, 5'd3, 5'd4, 5'd0, 5'd0, 16'd8, 26'd0, 32'h18});
        chk("nop_count", 106'(count), 106'(2));
        chk("nop_head", 106'(out_pc), 106'(32'h10));
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
        chk("nop_second", 106'(out_pc), 106'(32'h18));
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
        chk("nop_empty", 106'(out_valid), 106'(0));

        // Flush discards buffered entries and the same-cycle input; next input flows through.
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, add_word(32'(i)));
        drive(1'b0, 1'b1, 1'b0, 1'b1, add_word(32'h99));
        chk("flush_count", 106'(count), 106'(0));
        chk("flush_valid", 106'(out_valid), 106'(0));
        drive(1'b0, 1'b1, 1'b0, 1'b0, add_word(32'h40));
        chk("post_flush_valid", 106'(out_valid), 106'(1));
        chk("post_flush_pc", 106'(out_pc), 106'(32'h40));

        // Randomized traffic with shifting drain pressure, rare flushes and resets.
        for (int c = 0; c < 1200; c++) begin
            if (c % 100 == 0) pct = $urandom_range(10, 90);
            rnd = {$urandom, $urandom, $urandom, $urandom};
            w = rnd[105:0];
            if ($urandom_range(0, 3) == 0) w[105:32] = 74'd0;
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 99) < pct, $urandom_range(0, 59) == 0, w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
